// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, flag-position and state definitions shared by the 8085 execution stage and ALU
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADC = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SBB = 4'b0011;
  localparam logic [3:0] OP_ANA = 4'b0100;
  localparam logic [3:0] OP_XRA = 4'b0101;
  localparam logic [3:0] OP_ORA = 4'b0110;
  localparam logic [3:0] OP_CMP = 4'b0111;
  localparam logic [3:0] OP_INR = 4'b1000;
  localparam logic [3:0] OP_DCR = 4'b1001;

  localparam int FLAG_CY = 0;
  localparam int FLAG_P  = 2;
  localparam int FLAG_AC = 4;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_S  = 7;

  localparam logic [7:0] FLAG_MASK_DEF = 8'hD5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } seq_state_t;

  function automatic logic is_incdec(input logic [3:0] op);
    return (op == OP_INR) || (op == OP_DCR);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - execution stage owning A, F and TEMP around the 8085 ALU
import alu_pkg::*;

module alu_sequencer #(
  parameter logic [7:0] FLAG_MASK = FLAG_MASK_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] op,
  input  logic [7:0] src_b,
  input  logic       dst_is_acc,
  input  logic       acc_load,
  input  logic [7:0] acc_din,
  output logic       alu_enable,
  output logic [3:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [7:0] alu_f,
  input  logic [7:0] alu_r,
  input  logic [7:0] alu_fo,
  input  logic       alu_fwr_n,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       wb_en,
  output logic [7:0] wb_data,
  output logic [7:0] acc,
  output logic [7:0] flags
);

  seq_state_t r_state;
  logic [3:0] r_op;
  logic [7:0] r_temp;
  logic       r_dst_acc;
  logic [7:0] r_acc;
  logic [7:0] r_flags;
  logic [7:0] r_res;
  logic [7:0] r_fo;
  logic       r_fwr_n;
  logic [7:0] r_wb_data;
  logic       r_alu_en;
  logic       r_busy;
  logic       r_done;
  logic       r_err;
  logic       r_wb_en;

  logic w_op_valid;
  logic w_to_wb;

  assign w_op_valid = (r_op <= OP_DCR);
  // INR/DCR on a register other than A: result leaves through wb_data, not A
  assign w_to_wb    = is_incdec(r_op) && !r_dst_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_op      <= 4'd0;
      r_temp    <= 8'h00;
      r_dst_acc <= 1'b0;
      r_acc     <= 8'h00;
      r_flags   <= 8'h00;
      r_res     <= 8'h00;
      r_fo      <= 8'h00;
      r_fwr_n   <= 1'b1;
      r_wb_data <= 8'h00;
      r_alu_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_wb_en   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_wb_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (acc_load) begin
            r_acc <= acc_din;
          end else if (start) begin
            r_op      <= op;
            r_temp    <= src_b;
            r_dst_acc <= dst_is_acc;
            r_busy    <= 1'b1;
            r_state   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_alu_en <= 1'b1;
          r_state  <= ST_EXEC;
        end
        ST_EXEC: begin
          r_res    <= alu_r;
          r_fo     <= alu_fo;
          r_fwr_n  <= alu_fwr_n;
          r_alu_en <= 1'b0;
          r_done   <= 1'b1;
          r_err    <= !w_op_valid;
          // wb_data is loaded here so it is already valid during the WB pulse
          if (w_op_valid && w_to_wb) begin
            r_wb_en   <= 1'b1;
            r_wb_data <= alu_r;
          end
          r_state <= ST_WB;
        end
        ST_WB: begin
          if (w_op_valid) begin
            if (r_op != OP_CMP && !w_to_wb) r_acc <= r_res;
            if (!r_fwr_n) r_flags <= r_fo & FLAG_MASK;
          end
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign alu_enable = r_alu_en;
  assign alu_op     = r_op;
  assign alu_a      = w_to_wb ? r_temp : r_acc;
  assign alu_b      = r_temp;
  assign alu_f      = r_flags;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign wb_en      = r_wb_en;
  assign wb_data    = r_wb_data;
  assign acc        = r_acc;
  assign flags      = r_flags;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed and randomised checks of alu_sequencer against a reference 8085 ALU
module tb_alu_sequencer;
  import alu_pkg::*;

  typedef struct {
    logic [7:0] acc;
    logic [7:0] flags;
    logic [7:0] wbd;
    logic       wb;
    logic       err;
  } exp_t;

  logic       clk, rst, start, dst_is_acc, acc_load;
  logic [3:0] op;
  logic [7:0] src_b, acc_din;
  logic       alu_enable, alu_fwr_n, busy, done, err, wb_en;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_f, alu_r, alu_fo, wb_data, acc, flags;
  logic [15:0] w_alu;

  int   n_pass = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic [7:0] m_acc = 8'h00, m_flags = 8'h00, m_wbd = 8'h00;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_b(src_b),
    .dst_is_acc(dst_is_acc), .acc_load(acc_load), .acc_din(acc_din),
    .alu_enable(alu_enable), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_f(alu_f), .alu_r(alu_r), .alu_fo(alu_fo), .alu_fwr_n(alu_fwr_n),
    .busy(busy), .done(done), .err(err), .wb_en(wb_en), .wb_data(wb_data),
    .acc(acc), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: returns {result, flags}; F bit 1 is driven high so the mask is exercised
  function automatic logic [15:0] alu_ref(input logic [3:0] o, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] f);
    logic [8:0] s;
    logic       ac, c;
    s  = 9'd0;
    ac = 1'b0;
    c  = f[0];
    case (o)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; ac = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15; c = s[8]; end
      OP_ADC: begin s = {1'b0, a} + {1'b0, b} + {8'd0, f[0]};
                    ac = ({1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, f[0]}) > 5'd15; c = s[8]; end
      OP_SUB, OP_CMP: begin s = {1'b0, a} - {1'b0, b}; ac = a[3:0] < b[3:0]; c = s[8]; end
      OP_SBB: begin s = {1'b0, a} - {1'b0, b} - {8'd0, f[0]};
                    ac = {1'b0, a[3:0]} < ({1'b0, b[3:0]} + {4'd0, f[0]}); c = s[8]; end
      OP_ANA: begin s = {1'b0, a & b}; ac = a[3] | b[3]; c = 1'b0; end
      OP_XRA: begin s = {1'b0, a ^ b}; c = 1'b0; end
      OP_ORA: begin s = {1'b0, a | b}; c = 1'b0; end
      OP_INR: s = {1'b0, a + 8'd1};
      OP_DCR: s = {1'b0, a - 8'd1};
      default: s = 9'd0;
    endcase
    return {s[7:0], s[7], (s[7:0] == 8'h00), 1'b0, ac, 1'b0, ~^s[7:0], 1'b1, c};
  endfunction

  always_comb begin
    w_alu     = alu_ref(alu_op, alu_a, alu_b, alu_f);
    alu_r     = (alu_op == OP_CMP) ? 8'hA5 : w_alu[15:8];
    alu_fo    = w_alu[7:0];
    alu_fwr_n = !(alu_enable && alu_op <= OP_DCR);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_acc_load(input logic [7:0] v);
    @(posedge clk); #1 acc_load = 1'b1; acc_din = v;
    @(posedge clk); #1 acc_load = 1'b0;
    @(negedge clk);
    chk("acc_load", acc, v);
    m_acc = v;
  endtask

  // pester: while busy, re-drive start and acc_load; both must be ignored
  task automatic do_op(input logic [3:0] o, input logic [7:0] b, input logic d, input logic pester);
    exp_t e;
    logic [15:0] rf;
    logic [7:0]  a_in;
    int n, wbn, extra;
    bit seen;
    a_in = (is_incdec(o) && !d) ? b : m_acc;
    rf   = alu_ref(o, a_in, b, m_flags);
    e.acc = m_acc; e.flags = m_flags; e.wbd = m_wbd; e.wb = 1'b0; e.err = 1'b0;
    if (o > OP_DCR) e.err = 1'b1;
    else begin
      e.flags = rf[7:0] & 8'hD5;
      if (is_incdec(o) && !d) begin e.wb = 1'b1; e.wbd = rf[15:8]; end
      else if (o != OP_CMP) e.acc = rf[15:8];
    end
    sb.push_back(e);
    m_acc = e.acc; m_flags = e.flags; m_wbd = e.wbd;

    @(posedge clk); #1 start = 1'b1; op = o; src_b = b; dst_is_acc = d;
    @(posedge clk); #1 start = 1'b0;
    if (pester) begin start = 1'b1; op = OP_ADD; src_b = 8'h55; acc_load = 1'b1; acc_din = 8'hAA; end
    n = 0; wbn = 0; seen = 0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if (wb_en) wbn++;
      if (done) seen = 1;
      if (!seen && n == 2 && pester) begin
        @(posedge clk); #1 start = 1'b0; acc_load = 1'b0;
      end
    end
    chk("done_seen", seen, 1);
    e = sb.pop_front();
    if (seen) begin
      chk("latency", n, 3);
      chk("err", err, e.err);
      chk("wb_en", wb_en, e.wb);
      if (e.wb) chk("wb_data", wb_data, e.wbd);
      chk("wb_en_count", wbn, e.wb);
      @(negedge clk);
      chk("acc", acc, e.acc);
      chk("flags", flags, e.flags);
      chk("busy_after", busy, 0);
      if (pester) begin
        extra = 0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (done) extra++; end
        chk("single_done", extra, 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 4'd0; src_b = 8'h00; dst_is_acc = 1'b1;
    acc_load = 1'b0; acc_din = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_acc", acc, 8'h00);
    chk("rst_flags", flags, 8'h00);
    chk("rst_ctl", {alu_enable, busy, done, err, wb_en}, 5'b0);
    chk("rst_wb_data", wb_data, 8'h00);

    do_acc_load(8'h3A);
    do_op(OP_ADD, 8'hC6, 1'b1, 1'b0);
    chk("t1_acc", acc, 8'h00);
    chk("t1_flags", flags, 8'h55);

    do_op(OP_INR, 8'hFF, 1'b0, 1'b0);
    chk("t3_wb_data", wb_data, 8'h00);
    chk("t3_acc", acc, 8'h00);
    chk("t3_flags", flags, 8'h45);

    do_acc_load(8'h05);
    do_op(OP_CMP, 8'h05, 1'b1, 1'b0);
    chk("t2_acc", acc, 8'h05);
    chk("t2_flags", flags, 8'h44);

    do_op(4'b1100, 8'h33, 1'b1, 1'b0);
    chk("t4_acc", acc, 8'h05);
    chk("t4_flags", flags, 8'h44);

    // reset while in EXEC drops the op
    @(posedge clk); #1 start = 1'b1; op = OP_ADD; src_b = 8'h11; dst_is_acc = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("t5_in_exec", alu_enable, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_done", done, 0);
    chk("t5_acc", acc, 8'h00);
    chk("t5_flags", flags, 8'h00);
    chk("t5_busy", busy, 0);
    begin
      int dn;
      dn = 0;
      for (int i = 0; i < 5; i++) begin @(negedge clk); if (done) dn++; end
      chk("t5_no_done", dn, 0);
    end
    m_acc = 8'h00; m_flags = 8'h00; m_wbd = 8'h00;

    // acc_load beats start in the same IDLE cycle
    @(posedge clk); #1 acc_load = 1'b1; acc_din = 8'h77; start = 1'b1; op = OP_ADD; src_b = 8'h01;
    @(posedge clk); #1 acc_load = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_acc", acc, 8'h77);
    m_acc = 8'h77;
    do_op(OP_SUB, 8'h10, 1'b1, 1'b1);
    chk("t6_acc_sub", acc, 8'h67);

    for (int k = 0; k < 10; k++) begin
      logic [3:0] ro;
      ro = 4'($urandom_range(0, 11));
      do_op(ro, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
